// File: rtl/two_digits_pkg.sv
// two_digits_pkg: segment constants and binary-to-BCD helper for the two-digit HEX driver
package two_digits_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [13:0] HEXS_OFF = 14'h3FFF;
  localparam logic [6:0] MAX_VAL = 7'd99;
  // Compare/subtract conversion: tens counts the decade thresholds crossed, ones is the remainder
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = '0;
    for (int i = 1; i <= 9; i++) tens = tens + 4'(v >= 7'(10 * i));
    rem = v - 7'(tens) * 7'd10;
    return {tens, rem[3:0]};
  endfunction
endpackage

// File: rtl/two_digits_seg7_decode.sv
// seg7_decode: combinational BCD to active-low seven-segment (gfedcba), 10..15 blank
import two_digits_pkg::*;
module seg7_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/two_digits.sv
// two_digits: registered 0..99 two-digit HEX driver with dash-on-overflow.
// Define TWO_DIGITS_BLANK_ZERO_EN to suppress the leading tens zero.
import two_digits_pkg::*;
module two_digits (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [6:0]  data_in,
  output logic [13:0] hexs,
  output logic        overflow
);
  logic [7:0] bcd;
  logic [6:0] tens_seg, ones_seg, tens_d;
  logic ovf_d;
  assign bcd = to_bcd(data_in);
  assign ovf_d = data_in > MAX_VAL;
  seg7_decode u_tens (.bcd(bcd[7:4]), .seg(tens_seg));
  seg7_decode u_ones (.bcd(bcd[3:0]), .seg(ones_seg));
`ifdef TWO_DIGITS_BLANK_ZERO_EN
  assign tens_d = bcd[7:4] == 4'd0 ? SEG_BLANK : tens_seg;
`else
  assign tens_d = tens_seg;
`endif
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hexs <= HEXS_OFF;
      overflow <= 1'b0;
    end else if (load) begin
      hexs <= ovf_d ? {SEG_DASH, SEG_DASH} : {tens_d, ones_seg};
      overflow <= ovf_d;
    end
  end
endmodule

// File: tb/tb_two_digits.sv
// tb_two_digits: directed and sweep checks of the two_digits HEX driver
module tb_two_digits;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic load = 1'b0;
  logic [6:0] data_in = '0;
  logic [13:0] hexs;
  logic overflow;
  int vectors = 0;
  int errors = 0;
  logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  two_digits dut (.clock(clock), .resetn(resetn), .load(load), .data_in(data_in), .hexs(hexs), .overflow(overflow));

  always #5 clock = ~clock;

  function automatic logic [13:0] model(input int v);
    logic [6:0] t;
    if (v > 99) return 14'h1FBF;
    t = lut[v / 10];
`ifdef TWO_DIGITS_BLANK_ZERO_EN
    if (v < 10) t = 7'h7F;
`endif
    return {t, lut[v % 10]};
  endfunction

  task automatic chk(input string tag, input logic [13:0] eh, input logic eo);
    vectors++;
    assert (hexs === eh && overflow === eo) else begin
      errors++;
      $error("FAIL %s: observed hexs=%h ovf=%b expected hexs=%h ovf=%b", tag, hexs, overflow, eh, eo);
    end
  endtask

  task automatic cyc(input logic l, input logic [6:0] d);
    load = l;
    data_in = d;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    chk("reset", 14'h3FFF, 1'b0);
    load = 1'b1;
    data_in = 7'd42;
    @(negedge clock);
    chk("reset_overrides_load", 14'h3FFF, 1'b0);
    resetn = 1'b1;
    cyc(1'b1, 7'd42);
    chk("load42", 14'h0CA4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 7'd13);
      chk("hold42", 14'h0CA4, 1'b0);
    end
    cyc(1'b1, 7'd99);
    chk("load99", 14'h0810, 1'b0);
    cyc(1'b1, 7'd100);
    chk("load100", 14'h1FBF, 1'b1);
    cyc(1'b1, 7'd127);
    chk("load127", 14'h1FBF, 1'b1);
    cyc(1'b1, 7'd7);
`ifdef TWO_DIGITS_BLANK_ZERO_EN
    chk("load7", 14'h3FF8, 1'b0);
`else
    chk("load7", 14'h2078, 1'b0);
`endif
    cyc(1'b1, 7'd0);
`ifdef TWO_DIGITS_BLANK_ZERO_EN
    chk("load0", 14'h3FC0, 1'b0);
`else
    chk("load0", 14'h2040, 1'b0);
`endif
    cyc(1'b1, 7'd58);
    chk("load58", {7'h12, 7'h00}, 1'b0);
    cyc(1'b1, 7'd101);
    chk("load101", 14'h1FBF, 1'b1);
    #2 resetn = 1'b0;
    #1 chk("async_reset", 14'h3FFF, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    cyc(1'b1, 7'd61);
    chk("after_reset61", {7'h02, 7'h79}, 1'b0);
    for (int v = 0; v < 128; v++) begin
      cyc(1'b1, 7'(v));
      chk($sformatf("sweep%0d", v), model(v), v > 99);
    end
    cyc(1'b0, 7'd5);
    chk("hold_after_sweep", 14'h1FBF, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $fatal(1, "FAIL timeout: observed no finish, expected finish before 20000");
  end
endmodule
